// File: rtl/decoder_scan_sequencer.sv
// Select generator for a 3-to-8 line decoder: walks the enabled lines in
// ascending order with a per-line dwell and a blanking gap between lines.
module decoder_scan_sequencer #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       mask,
    output logic [2:0]       s,
    output logic             s_valid,
    output logic             busy,
    output logic             frame,
    output logic             done
);

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DWELL
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [BW-1:0]    blank_cnt, blank_cnt_n;
    logic [2:0]       s_n;
    logic             s_valid_n, busy_n, frame_n, done_n;

    logic [2:0] low, up, nxt;
    logic       up_found, wrap;
    logic       go, abort, dwell_end, blank_end, expire;

    // Lowest enabled line, and lowest enabled line above the current one
    always_comb begin
        low      = 3'd0;
        up       = 3'd0;
        up_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                low = 3'(i);
                if (i > int'(s)) begin
                    up       = 3'(i);
                    up_found = 1'b1;
                end
            end
        end
    end

    assign wrap      = !up_found;
    assign nxt       = up_found ? up : low;
    assign go        = en && (mask != 8'd0) && (!mode || start);
    assign abort     = !en || (mask == 8'd0);
    assign dwell_end = (dwell_cnt == '0);
    assign blank_end = (blank_cnt == BLAST);
    assign expire    = (state == DWELL) && !abort && dwell_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            s         <= 3'd0;
            s_valid   <= 1'b0;
            busy      <= 1'b0;
            frame     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_cnt_n;
            blank_cnt <= blank_cnt_n;
            s         <= s_n;
            s_valid   <= s_valid_n;
            busy      <= busy_n;
            frame     <= frame_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (go) state_n = (BLANK_CYC == 0) ? DWELL : BLANK;
            end
            BLANK: begin
                if (abort)          state_n = IDLE;
                else if (blank_end) state_n = DWELL;
            end
            DWELL: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (dwell_end) begin
                    if (wrap && mode)    state_n = IDLE;
                    else if (nxt == s)   state_n = DWELL;
                    else                 state_n = (BLANK_CYC == 0) ? DWELL : BLANK;
                end
            end
            default: state_n = IDLE;
        endcase

        blank_cnt_n = '0;
        if (state == BLANK && state_n == BLANK) blank_cnt_n = blank_cnt + BW'(1);

        // Dwell length is latched from div on every fresh dwell
        dwell_cnt_n = '0;
        if (state_n == DWELL) begin
            if (state == DWELL && !dwell_end) dwell_cnt_n = dwell_cnt - DIV_W'(1);
            else                              dwell_cnt_n = div;
        end
    end

    always_comb begin
        s_n = s;
        if (state == IDLE && go)        s_n = low;
        if (expire && !(wrap && mode))  s_n = nxt;
        s_valid_n = (state_n == DWELL);
        busy_n    = (state_n != IDLE);
        frame_n   = expire && wrap;
        done_n    = expire && wrap && mode;
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer: stimulus queues the expected
// dwell/blank/frame events, a negedge monitor pops and compares them.
module tb_decoder_scan_sequencer;

    localparam int K_RISE  = 1;
    localparam int K_FALL  = 2;
    localparam int K_FRAME = 3;

    typedef struct {
        int kind;
        int s;
        int a;
        int b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, start;
    logic [15:0] div;
    logic [7:0]  mask;
    logic [2:0]  s;
    logic        s_valid, busy, frame, done;

    int   errors = 0;
    int   checks = 0;
    ev_t  exq[$];

    logic       prev_valid = 1'b0;
    logic [2:0] prev_s = 3'd0;
    int         run_len = 0;
    int         gap = 0;

    decoder_scan_sequencer #(.DIV_W(16), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
        .div(div), .mask(mask), .s(s), .s_valid(s_valid), .busy(busy),
        .frame(frame), .done(done)
    );

    always #5 clk = ~clk;

    task automatic push(input int kind, input int sv, input int a, input int b);
        ev_t e;
        e.kind = kind; e.s = sv; e.a = a; e.b = b;
        exq.push_back(e);
    endtask

    task automatic got(input int kind, input int sv, input int a, input int b);
        ev_t x;
        checks++;
        if (exq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d s=%0d a=%0d b=%0d, none queued",
                     kind, sv, a, b);
        end else begin
            x = exq.pop_front();
            if (x.kind != kind || x.s != sv || x.a != a || (x.b != 0 && x.b != b)) begin
                errors++;
                $display("FAIL event got kind=%0d s=%0d a=%0d b=%0d, need kind=%0d s=%0d a=%0d b=%0d",
                         kind, sv, a, b, x.kind, x.s, x.a, x.b);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        gap = gap + 1;
        if (prev_valid && !s_valid) got(K_FALL, int'(prev_s), run_len, 0);
        if (frame || done) begin
            got(K_FRAME, int'(s), int'({frame, done}), gap);
            gap = 0;
        end
        if (s_valid && !prev_valid) got(K_RISE, int'(s), 0, 0);
        if (s_valid && prev_valid && s != prev_s) begin
            checks++;
            errors++;
            $display("FAIL s_changed_while_valid got %0d need %0d", s, prev_s);
        end
        if (s_valid) run_len = prev_valid ? run_len + 1 : 1;
        else         run_len = 0;
        prev_valid = s_valid;
        prev_s     = s;
    end

    initial begin
        int t3[3];
        t3 = '{2, 5, 7};
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0;
        div = 16'd0; mask = 8'd0;
        tick(3);
        chk("reset_s", int'(s), 0);
        chk("reset_s_valid", int'(s_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame", int'(frame), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        tick(1);

        // Full mask, continuous, two complete scans
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 8; l++) begin
                push(K_RISE, l, 0, 0);
                push(K_FALL, l, 4, 0);
            end
            push(K_FRAME, 0, 2, (k == 0) ? 0 : 48);
        end
        mask = 8'hFF; div = 16'd3; mode = 1'b0; en = 1'b1;
        tick(97);
        en = 1'b0;
        tick(3);
        chk("t2_idle_busy", int'(busy), 0);

        // Sparse mask 2,5,7
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 3; l++) begin
                push(K_RISE, t3[l], 0, 0);
                push(K_FALL, t3[l], 2, 0);
            end
            push(K_FRAME, 2, 2, (k == 0) ? 0 : 12);
        end
        mask = 8'b1010_0100; div = 16'd1; en = 1'b1;
        tick(25);
        en = 1'b0;
        tick(3);

        // Single pass with a start while busy
        push(K_RISE, 0, 0, 0);
        push(K_FALL, 0, 1, 0);
        push(K_RISE, 7, 0, 0);
        push(K_FALL, 7, 1, 0);
        push(K_FRAME, 7, 3, 0);
        mode = 1'b1; mask = 8'h81; div = 16'd0; en = 1'b1;
        tick(2);
        chk("t4_wait_start_busy", int'(busy), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        chk("t4_end_s", int'(s), 7);
        chk("t4_end_s_valid", int'(s_valid), 0);
        chk("t4_end_busy", int'(busy), 0);

        // Single enabled line, continuous
        push(K_RISE, 4, 0, 0);
        push(K_FRAME, 4, 2, 0);
        push(K_FRAME, 4, 2, 2);
        push(K_FRAME, 4, 2, 2);
        push(K_FRAME, 4, 2, 2);
        push(K_FALL, 4, 9, 0);
        mode = 1'b0; mask = 8'h10; div = 16'd1;
        tick(11);
        en = 1'b0;
        tick(3);

        // Abort by en in DWELL at s=3
        push(K_RISE, 2, 0, 0);
        push(K_FALL, 2, 6, 0);
        push(K_RISE, 3, 0, 0);
        push(K_FALL, 3, 2, 0);
        mask = 8'h0C; div = 16'd5; en = 1'b1;
        tick(12);
        en = 1'b0;
        tick(1);
        chk("t6_abort_s", int'(s), 3);
        chk("t6_abort_s_valid", int'(s_valid), 0);
        chk("t6_abort_busy", int'(busy), 0);
        chk("t6_abort_done", int'(done), 0);

        // Abort by mask=0 in BLANK
        en = 1'b1;
        tick(1);
        chk("t6_blank_busy", int'(busy), 1);
        mask = 8'h00;
        tick(1);
        chk("t6_mask_abort_busy", int'(busy), 0);
        chk("t6_mask_abort_s", int'(s), 2);
        tick(2);

        // Start with empty mask does nothing
        mode = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("t6_nomask_busy", int'(busy), 0);
        chk("t6_nomask_s_valid", int'(s_valid), 0);
        en = 1'b0;
        tick(2);

        // Reset mid-DWELL at s=5
        push(K_RISE, 5, 0, 0);
        push(K_FALL, 5, 4, 0);
        mode = 1'b0; mask = 8'h20; div = 16'd10; en = 1'b1;
        tick(6);
        chk("t1_pre_s", int'(s), 5);
        rst_n = 1'b0;
        tick(1);
        chk("t1_s", int'(s), 0);
        chk("t1_s_valid", int'(s_valid), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_frame", int'(frame), 0);
        chk("t1_done", int'(done), 0);
        en = 1'b0;
        rst_n = 1'b1;
        tick(5);

        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d left need 0", exq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
